// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_seq
// Brief    : Core reset sequencer driven by PLL lock. Synchronizes the lock
//            indication, requires a stable-lock window and a hold period
//            before releasing reset, re-asserts reset on lock loss and keeps
//            sticky loss diagnostics.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  output logic       rst_n_out,
  output logic       lock_lost,
  output logic [7:0] relock_count,
  output logic [1:0] state_o
);

  // One counter serves both the stable window and the hold period, so it is
  // sized for whichever of the two is longer.
  localparam int c_CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST   = c_CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO    = '0;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  state_t                 r_state;
  state_t                 w_next_state;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     w_next_cnt;
  logic                   w_loss_in_run;

  // Synchronizer chain for the asynchronous lock input; bit 0 samples pll_lock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // Next-state and counter decode; a lock drop always takes priority over
  // advancing, and the counter restarts from zero on every state change.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = c_CNT_ZERO;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_next_state = ST_STABLE;
        end
      end
      ST_STABLE: begin
        if (!w_lock_s) begin
          w_next_state = ST_WAIT_LOCK;
        end else if (r_cnt == c_STABLE_LAST) begin
          w_next_state = ST_HOLD;
        end else begin
          w_next_cnt = r_cnt + c_CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (!w_lock_s) begin
          w_next_state = ST_WAIT_LOCK;
        end else if (r_cnt == c_HOLD_LAST) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_cnt = r_cnt + c_CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_next_state = ST_WAIT_LOCK;
        end
      end
      default: begin
        w_next_state = ST_WAIT_LOCK;
      end
    endcase
  end

  // Only a loss seen while running counts as a diagnostic event.
  assign w_loss_in_run = (r_state == ST_RUN) && !w_lock_s;

  // State, counter and the core reset; the reset output is decoded from the
  // next state so it moves on the same edge as the state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_WAIT_LOCK;
      r_cnt     <= c_CNT_ZERO;
      rst_n_out <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      rst_n_out <= (w_next_state == ST_RUN);
    end
  end

  // Sticky loss flag and saturating loss counter, cleared only by resetn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_lost    <= 1'b0;
      relock_count <= 8'd0;
    end else if (w_loss_in_run) begin
      lock_lost <= 1'b1;
      if (relock_count != 8'hFF) begin
        relock_count <= relock_count + 8'd1;
      end
    end
  end

  assign state_o = r_state;

endmodule
`default_nettype wire
